// File: rtl/blink_monitor_if.sv
// Bundle of the blink monitor's LED/clear inputs and measurement outputs.
//   led_i, clear_i           : driven by the master (bench or loopback logic)
//   blink_pulse_o            : 1-cycle pulse per valid blink
//   blink_count_o            : valid blink count (wraps)
//   last_on/off_cycles_o     : length of the last completed on/off phase
//   short_err_o, long_err_o  : sticky phase-length errors
//   busy_o                   : monitor is tracking a phase
interface blink_monitor_if #(
  parameter int CountW      = 16,
  parameter int BlinkCountW = 16
);
  logic                   led_i;
  logic                   clear_i;
  logic                   blink_pulse_o;
  logic [BlinkCountW-1:0] blink_count_o;
  logic [CountW-1:0]      last_on_cycles_o;
  logic [CountW-1:0]      last_off_cycles_o;
  logic                   short_err_o;
  logic                   long_err_o;
  logic                   busy_o;

  modport master (
    output led_i, clear_i,
    input  blink_pulse_o, blink_count_o, last_on_cycles_o, last_off_cycles_o,
    input  short_err_o, long_err_o, busy_o
  );

  modport slave (
    input  led_i, clear_i,
    output blink_pulse_o, blink_count_o, last_on_cycles_o, last_off_cycles_o,
    output short_err_o, long_err_o, busy_o
  );
endinterface

// File: rtl/blink_monitor.sv
// Receive-side checker for an LED blink waveform. The asynchronous LED level is
// synchronized, every on/off phase is measured in clock cycles, valid on phases
// are counted as blinks, and sticky short/long phase errors are latched.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (priority over clear_i)
//   bus    : blink_monitor_if slave (led_i, clear_i in; statistics out)
module blink_monitor #(
  parameter int MinHalfCycles = 4,
  parameter int MaxHalfCycles = 8,
  parameter int CountW        = 16,
  parameter int BlinkCountW   = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  blink_monitor_if.slave bus
);

  localparam logic [CountW-1:0] MinC = CountW'(MinHalfCycles);
  localparam logic [CountW-1:0] MaxC = CountW'(MaxHalfCycles);
  localparam logic [CountW-1:0] OneC = CountW'(1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
    return (&v) ? v : v + OneC;
  endfunction

  logic sync_p0, sync_p1, prev_p2;
  logic rise, fall;

  state_t state, state_next;

  logic enter_phase, end_on, end_off, phase_end, count_en;
  logic is_short, is_blink, hit_long;

  logic [CountW-1:0]      cnt_q;
  logic [CountW-1:0]      last_on_q, last_off_q;
  logic [BlinkCountW-1:0] count_q;
  logic                   pulse_q, short_q, long_q;

  // Stage p0/p1: two-flop synchronizer; p2: previous synchronized level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= bus.led_i;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;

  // FSM state register; clear_i drops back to IDLE and ignores a same-cycle edge
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) state <= IDLE;
    else                      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = ON;
               else if (fall) state_next = OFF;
      ON:      if (fall) state_next = OFF;
      OFF:     if (rise) state_next = ON;
      default: state_next = IDLE;
    endcase
  end

  // Event decode from the current state and the synchronized edges
  always_comb begin
    enter_phase = 1'b0;
    end_on      = 1'b0;
    end_off     = 1'b0;
    count_en    = 1'b0;
    case (state)
      IDLE:    enter_phase = rise | fall;
      ON:      begin end_on  = fall; count_en = ~rise & ~fall; end
      OFF:     begin end_off = rise; count_en = ~rise & ~fall; end
      default: ;
    endcase
    phase_end = end_on | end_off;
    is_short  = cnt_q < MinC;
    is_blink  = end_on & ~is_short & (cnt_q <= MaxC);
    // Flag a stuck level as soon as the phase outgrows the legal maximum
    hit_long  = count_en & (cnt_q == MaxC);
  end

  // Stage boundary: phase counter and measurement registers
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      cnt_q      <= '0;
      last_on_q  <= '0;
      last_off_q <= '0;
      count_q    <= '0;
      pulse_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      pulse_q <= is_blink;
      if (enter_phase || phase_end) cnt_q <= OneC;
      else if (count_en)            cnt_q <= sat_inc(cnt_q);
      if (end_on)                   last_on_q  <= cnt_q;
      if (end_off)                  last_off_q <= cnt_q;
      if (phase_end && is_short)    short_q    <= 1'b1;
      if (hit_long)                 long_q     <= 1'b1;
      if (is_blink)                 count_q    <= count_q + 1'b1;
    end
  end

  assign bus.blink_pulse_o     = pulse_q;
  assign bus.blink_count_o     = count_q;
  assign bus.last_on_cycles_o  = last_on_q;
  assign bus.last_off_cycles_o = last_off_q;
  assign bus.short_err_o       = short_q;
  assign bus.long_err_o        = long_q;
  assign bus.busy_o            = (state != IDLE);

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: directed scenarios plus randomized phase lengths,
// clears and resets. A reference model works on the sequence of LED samples
// (run lengths delayed by the two-clock synchronizer latency) and queues the
// expected blink count for each pulse; a negedge monitor pops and compares.
module tb_blink_monitor;
  localparam int MIN = 4;
  localparam int MAX = 8;
  localparam int CW  = 5;
  localparam int BW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blink_monitor_if #(.CountW(CW), .BlinkCountW(BW)) bus();

  blink_monitor #(
    .MinHalfCycles(MIN), .MaxHalfCycles(MAX), .CountW(CW), .BlinkCountW(BW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  hist [3];
  bit  m_armed;
  int  m_run, m_count, m_last_on, m_last_off;
  bit  m_short, m_long;
  int  exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_armed = 0; m_run = 0; m_count = 0;
    m_last_on = 0; m_last_off = 0; m_short = 0; m_long = 0;
  endtask

  // The transition the monitor reacts to at clock k is between the LED samples
  // taken at clocks k-3 and k-2; samples taken during reset read as 0.
  task automatic model_step();
    int y, yp;
    if (rst) begin
      model_zero();
      hist = '{0, 0, 0};
    end else begin
      y  = hist[1];
      yp = hist[2];
      if (bus.clear_i) begin
        model_zero();
      end else if (y != yp) begin
        if (m_armed) begin
          if (yp == 1) m_last_on = m_run; else m_last_off = m_run;
          if (m_run < MIN) m_short = 1;
          else if (yp == 1 && m_run <= MAX) begin
            m_count = (m_count + 1) % (1 << BW);
            exp_q.push_back(m_count);
          end
        end
        m_armed = 1;
        m_run   = 1;
      end else if (m_armed) begin
        if (m_run == MAX) m_long = 1;
        if (m_run < SAT) m_run++;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(bus.led_i);
    end
  endtask

  initial begin
    model_zero();
    hist = '{0, 0, 0};
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("pulse", int'(bus.blink_pulse_o), int'(exp_q.size() != 0));
      if (bus.blink_pulse_o && exp_q.size() != 0)
        chk("pulse_count", int'(bus.blink_count_o), exp_q.pop_front());
      else
        exp_q.delete();
      chk("blink_count", int'(bus.blink_count_o), m_count);
      chk("last_on", int'(bus.last_on_cycles_o), m_last_on);
      chk("last_off", int'(bus.last_off_cycles_o), m_last_off);
      chk("short_err", int'(bus.short_err_o), int'(m_short));
      chk("long_err", int'(bus.long_err_o), int'(m_long));
      chk("busy", int'(bus.busy_o), int'(m_armed));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic lvl, input int n);
    bus.led_i = lvl;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      bus.led_i = ~bus.led_i;
      step();
    end
    rst = 1'b0;
  endtask

  task automatic blinks(input int n, input int len);
    repeat (n) begin
      hold(1'b1, len);
      hold(1'b0, len);
    end
  endtask

  logic lvl;
  int   r;

  initial begin
    bus.led_i   = 1'b0;
    bus.clear_i = 1'b0;
    step();

    // Reset with the LED toggling
    do_reset();
    hold(1'b0, 4);

    // Nominal 5/5 after a first rise
    hold(1'b1, 5);
    blinks(1, 5);
    blinks(3, 5);
    hold(1'b0, 3);

    // Glitch in an off phase
    hold(1'b1, 2);
    hold(1'b0, 6);

    // Stuck high long enough to saturate the phase counter
    hold(1'b1, 40);
    hold(1'b0, 6);

    // Clear on the same clock the rise reaches the FSM
    bus.led_i = 1'b1;
    step();
    step();
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);

    // Reset mid-on after three valid blinks, then a fresh 5/5 cycle
    blinks(3, 5);
    hold(1'b1, 3);
    do_reset();
    hold(1'b0, 4);
    blinks(2, 5);

    // Enough nominal blinks to wrap the blink counter
    blinks(18, 6);

    // Random phase lengths with occasional clear and reset
    lvl = bus.led_i;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 79));
      if (r == 0) begin
        do_reset();
      end else if (r < 4) begin
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
      end
      lvl = ~lvl;
      if ($urandom_range(0, 1) == 0) hold(lvl, int'($urandom_range(MIN, MAX)));
      else                           hold(lvl, int'($urandom_range(1, 12)));
    end

    hold(1'b0, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
